// File: rtl/aes_enc_pkg.sv
// ============================================================================
// Module      : aes_enc_pkg
// Description : Shared types, constants and round helpers for aes_encrypt_core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_enc_pkg;

    localparam int NR_AES128 = 10;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD       = 4'd1,
        ADD_RK     = 4'd2,
        SUB_BYTES  = 4'd3,
        SHIFT_ROWS = 4'd4,
        MIX0       = 4'd5,
        MIX1       = 4'd6,
        MIX2       = 4'd7,
        MIX3       = 4'd8,
        DONE       = 4'd9
    } aes_state_t;

    // Indexed by the round number that the generated key belongs to.
    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_encrypt_core_if.sv
// ============================================================================
// Module      : aes_encrypt_core_if
// Description : Start/done handshake and 128-bit data bus of the AES core.
//               AES_ENC_LAST_KEY_EN adds the round-10 key output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_encrypt_core_if;
    logic         AES_START;
    logic         AES_DONE;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_DEC;
    logic [127:0] AES_MSG_ENC;
`ifdef AES_ENC_LAST_KEY_EN
    logic [127:0] AES_LAST_KEY;
`endif

    modport master (
`ifdef AES_ENC_LAST_KEY_EN
        input  AES_LAST_KEY,
`endif
        output AES_START, AES_KEY, AES_MSG_DEC,
        input  AES_DONE, AES_MSG_ENC
    );

    modport slave (
`ifdef AES_ENC_LAST_KEY_EN
        output AES_LAST_KEY,
`endif
        input  AES_START, AES_KEY, AES_MSG_DEC,
        output AES_DONE, AES_MSG_ENC
    );
endinterface

`default_nettype wire

// File: rtl/aes_sbox_fwd.sv
// ============================================================================
// Module      : aes_sbox_fwd
// Description : Combinational forward AES S-box, one byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox_fwd (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [0:255][7:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_sbox[i_byte];
endmodule

`default_nettype wire

// File: rtl/aes_encrypt_core.sv
// ============================================================================
// Module      : aes_encrypt_core
// Description : Iterative AES-128 encryption, round keys expanded on the fly.
//               Optional macro AES_ENC_LAST_KEY_EN exports the round-10 key.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_encrypt_core
    import aes_enc_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    aes_encrypt_core_if.slave bus
);
    generate
        if (NR != NR_AES128) begin : g_nr_check
            $error("aes_encrypt_core supports only NR = 10");
        end
    endgenerate

    aes_state_t   r_fsm;
    aes_state_t   w_fsm_next;
    logic [127:0] r_blk;
    logic [127:0] r_rk;
    logic [127:0] r_msg_enc;
    logic [3:0]   r_round;

    logic         w_last_round;
    logic [127:0] w_sub_blk;
    logic [31:0]  w_rot_word;
    logic [31:0]  w_sub_word;
    logic [7:0]   w_rcon;
    logic [31:0]  w_w4, w_w5, w_w6, w_w7;
    logic [127:0] w_next_rk;

    assign w_last_round = (r_round == 4'(NR_AES128));

    generate
        for (genvar i = 0; i < 16; i++) begin : g_state_sbox
            aes_sbox_fwd u_sbox (
                .i_byte (r_blk[127 - 8*i -: 8]),
                .o_byte (w_sub_blk[127 - 8*i -: 8])
            );
        end
        for (genvar k = 0; k < 4; k++) begin : g_key_sbox
            aes_sbox_fwd u_sbox (
                .i_byte (w_rot_word[31 - 8*k -: 8]),
                .o_byte (w_sub_word[31 - 8*k -: 8])
            );
        end
    endgenerate

    // Key for round r+1 derived from the key currently held for round r.
    assign w_rot_word = rot_word(r_rk[31:0]);
    assign w_rcon     = w_last_round ? 8'h00 : RCON[r_round + 4'd1];
    assign w_w4       = r_rk[127:96] ^ w_sub_word ^ {w_rcon, 24'h0};
    assign w_w5       = r_rk[95:64] ^ w_w4;
    assign w_w6       = r_rk[63:32] ^ w_w5;
    assign w_w7       = r_rk[31:0]  ^ w_w6;
    assign w_next_rk  = {w_w4, w_w5, w_w6, w_w7};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE:       if (bus.AES_START) w_fsm_next = LOAD;
            LOAD:       w_fsm_next = ADD_RK;
            ADD_RK:     w_fsm_next = w_last_round ? DONE : SUB_BYTES;
            SUB_BYTES:  w_fsm_next = SHIFT_ROWS;
            SHIFT_ROWS: w_fsm_next = w_last_round ? ADD_RK : MIX0;
            MIX0:       w_fsm_next = MIX1;
            MIX1:       w_fsm_next = MIX2;
            MIX2:       w_fsm_next = MIX3;
            MIX3:       w_fsm_next = ADD_RK;
            DONE:       if (!bus.AES_START) w_fsm_next = IDLE;
            default:    w_fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_blk     <= '0;
            r_rk      <= '0;
            r_round   <= '0;
            r_msg_enc <= '0;
        end else begin
            case (r_fsm)
                LOAD: begin
                    r_blk     <= bus.AES_MSG_DEC;
                    r_rk      <= bus.AES_KEY;
                    r_round   <= '0;
                    r_msg_enc <= '0;
                end
                ADD_RK: begin
                    r_blk <= r_blk ^ r_rk;
                    if (w_last_round) begin
                        r_msg_enc <= r_blk ^ r_rk;
                    end else begin
                        r_round <= r_round + 4'd1;
                        r_rk    <= w_next_rk;
                    end
                end
                SUB_BYTES:  r_blk <= w_sub_blk;
                SHIFT_ROWS: r_blk <= shift_rows(r_blk);
                MIX0:       r_blk[127:96] <= mix_column(r_blk[127:96]);
                MIX1:       r_blk[95:64]  <= mix_column(r_blk[95:64]);
                MIX2:       r_blk[63:32]  <= mix_column(r_blk[63:32]);
                MIX3:       r_blk[31:0]   <= mix_column(r_blk[31:0]);
                default: ;
            endcase
        end
    end

`ifdef AES_ENC_LAST_KEY_EN
    logic [127:0] r_last_key;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_last_key <= '0;
        end else if (r_fsm == LOAD) begin
            r_last_key <= '0;
        end else if (r_fsm == ADD_RK && w_last_round) begin
            r_last_key <= r_rk;
        end
    end

    assign bus.AES_LAST_KEY = r_last_key;
`endif

    assign bus.AES_DONE    = (r_fsm == DONE);
    assign bus.AES_MSG_ENC = r_msg_enc;

endmodule

`default_nettype wire
